// File: rtl/gcm_pkg.sv
// Shared types, widths and helpers for the GCM GHASH input sequencer.
package gcm_pkg;
    localparam int BLK_W = 128;
    localparam int LEN_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_AAD,
        S_CT,
        S_LEN,
        S_FIN
    } state_t;

    // Byte counts of 0 or above 16 mean a full word.
    function automatic logic [4:0] norm_bytes(input logic [4:0] n);
        return (n == 5'd0 || n > 5'd16) ? 5'd16 : n;
    endfunction

    // Byte 0 sits in the top byte lane, so the mask grows downward from bit 127.
    function automatic logic [BLK_W-1:0] byte_mask(input logic [4:0] n);
        logic [4:0]       k;
        logic [BLK_W-1:0] m;
        k = norm_bytes(n);
        m = '0;
        for (int i = 0; i < 16; i++)
            if (i < int'(k)) m[BLK_W-1-8*i -: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [BLK_W-1:0] len_block(input logic [LEN_W-1:0] la,
                                                   input logic [LEN_W-1:0] lc);
        return {la, lc};
    endfunction
endpackage

// File: rtl/gcm_byte_pad.sv
// Zero-pads an input word down to its valid leading bytes.
module gcm_byte_pad
    import gcm_pkg::*;
(
    input  logic [BLK_W-1:0] in_data,
    input  logic [4:0]       in_bytes,
    output logic [BLK_W-1:0] padded
);
    assign padded = in_data & byte_mask(in_bytes);
endmodule

// File: rtl/gcm_ghash_sequencer.sv
// Formats AAD/ciphertext words into GHASH blocks: clear pulse, padded data
// blocks, then the {len(A), len(C)} length block.
module gcm_ghash_sequencer
    import gcm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             has_aad,
    input  logic             has_ct,
    input  logic [BLK_W-1:0] in_data,
    input  logic [4:0]       in_bytes,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ghash_start,
    output logic [BLK_W-1:0] ghash_data,
    output logic             ghash_valid,
    input  logic             ghash_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_t           state;
    logic             aad_en, ct_en, len_loaded;
    logic [LEN_W-1:0] len_a, len_c;
    logic [BLK_W-1:0] padded;
    logic [4:0]       nb;
    logic [LEN_W-1:0] n_bits;
    logic             out_free, accept;

    gcm_byte_pad u_pad (
        .in_data (in_data),
        .in_bytes(in_bytes),
        .padded  (padded)
    );

    assign nb          = norm_bytes(in_bytes);
    assign n_bits      = {{(LEN_W-8){1'b0}}, nb, 3'b000};
    assign out_free    = !ghash_valid || ghash_ready;
    assign in_ready    = (state == S_AAD || state == S_CT) && out_free;
    // start wins over a word offered in the same cycle
    assign accept      = in_valid && in_ready && !start;
    assign ghash_start = (state == S_CLEAR);
    assign done        = (state == S_FIN);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            aad_en      <= 1'b0;
            ct_en       <= 1'b0;
            len_loaded  <= 1'b0;
            len_a       <= '0;
            len_c       <= '0;
            ghash_data  <= '0;
            ghash_valid <= 1'b0;
            err         <= 1'b0;
        end else if (start) begin
            state       <= S_CLEAR;
            aad_en      <= has_aad;
            ct_en       <= has_ct;
            len_loaded  <= 1'b0;
            len_a       <= '0;
            len_c       <= '0;
            ghash_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (aad_en)     state <= S_AAD;
                    else if (ct_en) state <= S_CT;
                    else begin
                        // Empty message: the all-zero length block goes out right away.
                        ghash_data  <= len_block(len_a, len_c);
                        ghash_valid <= 1'b1;
                        len_loaded  <= 1'b1;
                        state       <= S_LEN;
                    end
                end
                S_AAD, S_CT: begin
                    if (accept) begin
                        ghash_data  <= padded;
                        ghash_valid <= 1'b1;
                        if (state == S_AAD) len_a <= len_a + n_bits;
                        else                len_c <= len_c + n_bits;
                        if (nb != 5'd16 && !in_last) err <= 1'b1;
                        if (in_last) state <= (state == S_AAD && ct_en) ? S_CT : S_LEN;
                    end else if (ghash_ready) begin
                        ghash_valid <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (!len_loaded) begin
                        if (out_free) begin
                            ghash_data  <= len_block(len_a, len_c);
                            ghash_valid <= 1'b1;
                            len_loaded  <= 1'b1;
                        end
                    end else if (ghash_valid && ghash_ready) begin
                        ghash_valid <= 1'b0;
                        state       <= S_FIN;
                    end
                end
                S_FIN: begin
                    len_loaded <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcm_ghash_sequencer.sv
// Randomized bench for gcm_ghash_sequencer against a queue-based message model.
module tb_gcm_ghash_sequencer;
    logic         clk = 1'b0;
    logic         reset, start, has_aad, has_ct;
    logic [127:0] in_data;
    logic [4:0]   in_bytes;
    logic         in_last, in_valid;
    logic         in_ready, ghash_start, ghash_valid, busy, done, err;
    logic [127:0] ghash_data;
    logic         ghash_ready;

    gcm_ghash_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .has_aad(has_aad), .has_ct(has_ct),
        .in_data(in_data), .in_bytes(in_bytes), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .ghash_start(ghash_start), .ghash_data(ghash_data),
        .ghash_valid(ghash_valid), .ghash_ready(ghash_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, tmo = 0;

    // message under test: word data, byte count, last flag, section (0 AAD, 1 CT)
    logic [127:0] w_d[$];
    logic [4:0]   w_n[$];
    bit           w_l[$];
    bit           w_sec[$];
    logic [127:0] exp_q[$];

    // monitor state (written only by the monitor)
    logic [127:0] got_q[$];
    int           got_cyc[$];
    int           cyc = 0, cnt_start = 0, cnt_done = 0, rdy_seen = 0, stab_viol = 0, start_cyc = 0;
    logic         err_at_done = 1'b0, pv = 1'b0, pr = 1'b0;
    logic [127:0] pd = '0;

    int  rdy_mode = 0;
    int  pat = 0;
    logic gs_seen, vld_after, err_after;

    initial begin
        ghash_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: ghash_ready = 1'b1;
                1: ghash_ready = 1'($urandom_range(0, 1));
                2: begin ghash_ready = (pat % 4 == 0) || (pat % 4 == 3); pat++; end
                default: ghash_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ghash_start) begin cnt_start <= cnt_start + 1; start_cyc <= cyc; end
        if (done) begin cnt_done <= cnt_done + 1; err_at_done <= err; end
        if (in_ready) rdy_seen <= rdy_seen + 1;
        if (ghash_valid && ghash_ready) begin got_q.push_back(ghash_data); got_cyc.push_back(cyc); end
        if (pv && !pr && !(ghash_valid && ghash_data == pd)) stab_viol <= stab_viol + 1;
        pv <= ghash_valid; pr <= ghash_ready; pd <= ghash_data;
    end

    task automatic gen_msg(input bit ha, input bit hc, input int na, input int nc, input bit partial);
        logic [4:0] n;
        int cnt, r;
        w_d.delete(); w_n.delete(); w_l.delete(); w_sec.delete();
        for (int s = 0; s < 2; s++) begin
            if ((s == 0 && ha) || (s == 1 && hc)) begin
                cnt = (s == 0) ? na : nc;
                for (int i = 0; i < cnt; i++) begin
                    n = 5'd16;
                    if (i == cnt - 1) begin
                        r = $urandom_range(0, 9);
                        if (r == 0)      n = 5'd0;
                        else if (r == 1) n = 5'd20;
                        else             n = 5'($urandom_range(1, 16));
                    end else if (partial && s == 0 && i == 0) n = 5'd7;
                    w_d.push_back({$urandom, $urandom, $urandom, $urandom});
                    w_n.push_back(n);
                    w_l.push_back(i == cnt - 1);
                    w_sec.push_back(s == 1);
                end
            end
        end
    endtask

    // Reference: each word keeps its first n bytes; lengths are 8*n summed per section.
    task automatic build_expect();
        logic [63:0]  la, lc;
        logic [127:0] d;
        int n, sh;
        exp_q.delete(); la = '0; lc = '0;
        for (int i = 0; i < w_d.size(); i++) begin
            n  = (w_n[i] == 0 || w_n[i] > 16) ? 16 : int'(w_n[i]);
            sh = 8 * (16 - n);
            d  = (w_d[i] >> sh) << sh;
            exp_q.push_back(d);
            if (w_sec[i]) lc = lc + 64'(8 * n);
            else          la = la + 64'(8 * n);
        end
        exp_q.push_back({la, lc});
    endtask

    task automatic pulse_start(input bit ha, input bit hc);
        @(posedge clk); #1;
        start = 1'b1; has_aad = ha; has_ct = hc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        gs_seen = ghash_start; vld_after = ghash_valid; err_after = err;
    endtask

    task automatic send_all();
        bit acc;
        @(posedge clk); #1;
        for (int i = 0; i < w_d.size(); i++) begin
            in_data = w_d[i]; in_bytes = w_n[i]; in_last = w_l[i]; in_valid = 1'b1;
            acc = 1'b0;
            for (int k = 0; k < 300 && !acc; k++) begin
                @(negedge clk);
                if (in_ready) acc = 1'b1;
                @(posedge clk); #1;
            end
            if (!acc) tmo++;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input int base);
        bit seen = 1'b0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            if (cnt_done > base) seen = 1'b1;
        end
        if (!seen) tmo++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, ghash_start, ghash_valid, busy, done, err} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000", {in_ready, ghash_start, ghash_valid, busy, done, err});
        end
        checks++;
        if (ghash_data !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", ghash_data); end
    endtask

    task automatic test_directed();
        int gb, sb, db, nb;
        rdy_mode = 0;
        w_d = '{{$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom}};
        w_n = '{5'd16, 5'd4, 5'd16}; w_l = '{1'b0, 1'b1, 1'b1}; w_sec = '{1'b0, 1'b0, 1'b1};
        build_expect();
        gb = got_q.size(); sb = cnt_start; db = cnt_done;
        pulse_start(1'b1, 1'b1);
        checks++; if (gs_seen !== 1'b1) begin errors++; $display("FAIL dir_gstart got %b exp 1", gs_seen); end
        send_all();
        wait_done(db);
        nb = got_q.size() - gb;
        checks++; if (nb != 4) begin errors++; $display("FAIL dir_count got %0d exp 4", nb); end
        for (int i = 0; i < exp_q.size() && i < nb; i++) begin
            checks++;
            if (got_q[gb+i] !== exp_q[i]) begin errors++; $display("FAIL dir_blk%0d got %h exp %h", i, got_q[gb+i], exp_q[i]); end
        end
        if (nb == 4) begin
            checks++;
            if (got_q[gb+1] !== {w_d[1][127:96], 96'h0}) begin errors++; $display("FAIL dir_pad got %h exp %h", got_q[gb+1], {w_d[1][127:96], 96'h0}); end
            checks++;
            if (got_q[gb+3] !== {64'd160, 64'd128}) begin errors++; $display("FAIL dir_len got %h exp %h", got_q[gb+3], {64'd160, 64'd128}); end
            checks++;
            if (got_cyc[gb+3] - got_cyc[gb+2] != 1) begin errors++; $display("FAIL dir_len_latency got %0d exp 1", got_cyc[gb+3] - got_cyc[gb+2]); end
            checks++;
            if (got_cyc[gb+1] - got_cyc[gb] != 1) begin errors++; $display("FAIL dir_throughput got %0d exp 1", got_cyc[gb+1] - got_cyc[gb]); end
        end
        checks++; if (cnt_start - sb != 1) begin errors++; $display("FAIL dir_starts got %0d exp 1", cnt_start - sb); end
        checks++; if (cnt_done - db != 1) begin errors++; $display("FAIL dir_done got %0d exp 1", cnt_done - db); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dir_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_empty();
        int gb, rb, db, nb;
        rdy_mode = 0;
        gen_msg(1'b0, 1'b0, 0, 0, 1'b0);
        gb = got_q.size(); rb = rdy_seen; db = cnt_done;
        pulse_start(1'b0, 1'b0);
        wait_done(db);
        nb = got_q.size() - gb;
        checks++; if (nb != 1) begin errors++; $display("FAIL empty_count got %0d exp 1", nb); end
        if (nb >= 1) begin
            checks++; if (got_q[gb] !== 128'h0) begin errors++; $display("FAIL empty_blk got %h exp 0", got_q[gb]); end
            checks++; if (got_cyc[gb] - start_cyc != 1) begin errors++; $display("FAIL empty_latency got %0d exp 1", got_cyc[gb] - start_cyc); end
        end
        checks++; if (rdy_seen != rb) begin errors++; $display("FAIL empty_in_ready got %0d exp 0", rdy_seen - rb); end
        checks++; if (cnt_done - db != 1) begin errors++; $display("FAIL empty_done got %0d exp 1", cnt_done - db); end
    endtask

    task automatic test_ready_toggle();
        int gb, vb, db, nb;
        gen_msg(1'b0, 1'b1, 0, 3, 1'b0);
        w_n[2] = 5'd16;
        build_expect();
        gb = got_q.size(); vb = stab_viol; db = cnt_done;
        rdy_mode = 2;
        pulse_start(1'b0, 1'b1);
        send_all();
        wait_done(db);
        rdy_mode = 0;
        nb = got_q.size() - gb;
        checks++; if (nb != 4) begin errors++; $display("FAIL tog_count got %0d exp 4", nb); end
        for (int i = 0; i < exp_q.size() && i < nb; i++) begin
            checks++;
            if (got_q[gb+i] !== exp_q[i]) begin errors++; $display("FAIL tog_blk%0d got %h exp %h", i, got_q[gb+i], exp_q[i]); end
        end
        if (nb == 4) begin
            checks++;
            if (got_q[gb+3] !== {64'd0, 64'd384}) begin errors++; $display("FAIL tog_len got %h exp %h", got_q[gb+3], {64'd0, 64'd384}); end
        end
        checks++; if (stab_viol != vb) begin errors++; $display("FAIL tog_stable got %0d exp 0 violations", stab_viol - vb); end
    endtask

    task automatic test_err();
        int gb, db, nb;
        rdy_mode = 1;
        gen_msg(1'b1, 1'b1, 2, 1, 1'b1);
        build_expect();
        gb = got_q.size(); db = cnt_done;
        pulse_start(1'b1, 1'b1);
        send_all();
        wait_done(db);
        rdy_mode = 0;
        nb = got_q.size() - gb;
        checks++; if (nb != exp_q.size()) begin errors++; $display("FAIL err_count got %0d exp %0d", nb, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < nb; i++) begin
            checks++;
            if (got_q[gb+i] !== exp_q[i]) begin errors++; $display("FAIL err_blk%0d got %h exp %h", i, got_q[gb+i], exp_q[i]); end
        end
        checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL err_at_done got %b exp 1", err_at_done); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
        db = cnt_done;
        pulse_start(1'b0, 1'b0);
        checks++; if (err_after !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err_after); end
        wait_done(db);
    endtask

    task automatic test_abort();
        int gb, sb, db, nb;
        rdy_mode = 3;
        gen_msg(1'b0, 1'b1, 0, 2, 1'b0);
        void'(w_d.pop_back()); void'(w_n.pop_back()); void'(w_l.pop_back()); void'(w_sec.pop_back());
        pulse_start(1'b0, 1'b1);
        send_all();
        @(negedge clk);
        checks++; if (ghash_valid !== 1'b1) begin errors++; $display("FAIL abort_pending got %b exp 1", ghash_valid); end
        gen_msg(1'b1, 1'b1, 1, 2, 1'b0);
        build_expect();
        sb = cnt_start; db = cnt_done;
        pulse_start(1'b1, 1'b1);
        gb = got_q.size();
        rdy_mode = 0;
        checks++; if (vld_after !== 1'b0) begin errors++; $display("FAIL abort_drop got %b exp 0", vld_after); end
        checks++; if (gs_seen !== 1'b1) begin errors++; $display("FAIL abort_gstart got %b exp 1", gs_seen); end
        send_all();
        wait_done(db);
        nb = got_q.size() - gb;
        checks++; if (nb != exp_q.size()) begin errors++; $display("FAIL abort_count got %0d exp %0d", nb, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < nb; i++) begin
            checks++;
            if (got_q[gb+i] !== exp_q[i]) begin errors++; $display("FAIL abort_blk%0d got %h exp %h", i, got_q[gb+i], exp_q[i]); end
        end
        checks++; if (cnt_start - sb < 1) begin errors++; $display("FAIL abort_starts got %0d exp >=1", cnt_start - sb); end
    endtask

    task automatic test_reset_mid();
        logic pre_v;
        rdy_mode = 0;
        pulse_start(1'b1, 1'b0);
        @(posedge clk); #1;
        in_data = {$urandom, $urandom, $urandom, $urandom}; in_bytes = 5'd16; in_last = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        pre_v = ghash_valid;
        checks++; if (pre_v !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b exp 1", pre_v); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, ghash_start, ghash_valid, busy, done, err} !== 6'b0 || ghash_data !== 128'h0) begin
            errors++; $display("FAIL rmid_outputs got %b/%h exp 0", {in_ready, ghash_start, ghash_valid, busy, done, err}, ghash_data);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if ({in_ready, busy} !== 2'b00) begin errors++; $display("FAIL rmid_idle got %b exp 00", {in_ready, busy}); end
    endtask

    task automatic test_random();
        int gb, db, nb;
        bit ha, hc;
        for (int it = 0; it < 10; it++) begin
            ha = 1'($urandom_range(0, 1)); hc = 1'($urandom_range(0, 1));
            gen_msg(ha, hc, $urandom_range(1, 4), $urandom_range(1, 4), 1'b0);
            build_expect();
            rdy_mode = 1;
            gb = got_q.size(); db = cnt_done;
            pulse_start(ha, hc);
            send_all();
            wait_done(db);
            nb = got_q.size() - gb;
            checks++; if (nb != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d exp %0d", it, nb, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < nb; i++) begin
                checks++;
                if (got_q[gb+i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_blk%0d got %h exp %h", it, i, got_q[gb+i], exp_q[i]); end
            end
            checks++; if (cnt_done - db != 1) begin errors++; $display("FAIL rnd%0d_done got %0d exp 1", it, cnt_done - db); end
        end
        rdy_mode = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; has_aad = 1'b0; has_ct = 1'b0;
        in_data = '0; in_bytes = 5'd16; in_last = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        @(posedge clk); #1 reset = 1'b0;
        test_directed();
        test_empty();
        test_ready_toggle();
        test_err();
        test_abort();
        test_reset_mid();
        test_random();
        checks++; if (tmo != 0) begin errors++; $display("FAIL timeouts got %0d exp 0", tmo); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcm_ghash_sequencer.md
# gcm_ghash_sequencer

Upstream formatter for the GCM GHASH accumulator. It takes AAD and ciphertext as 128-bit words with byte counts, zero-pads partial final blocks, and tracks bit lengths. It emits the GHASH clear pulse, then the padded AAD blocks, the padded ciphertext blocks, and finally the length block {len(A), len(C)}. Its output feeds GHASH `start`/`data_in`/`data_valid` directly.

## Interface
- BLK_W, 128, block width in bits
- LEN_W, 64, width of each bit-length field
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins (or aborts and restarts) a message
- has_aad  in  1  sampled with start; 0 = AAD section empty
- has_ct  in  1  sampled with start; 0 = ciphertext section empty
- in_data  in  BLK_W  input word; byte 0 at [127:120]
- in_bytes  in  5  valid bytes in word, 1..16 (0 or >16 treated as 16)
- in_last  in  1  last word of current section
- in_valid  in  1  input word valid
- in_ready  out  1  sequencer accepts word this cycle
- ghash_start  out  1  one-cycle clear pulse to GHASH
- ghash_data  out  BLK_W  padded block to GHASH
- ghash_valid  out  1  ghash_data valid
- ghash_ready  in  1  GHASH accepts block
- busy  out  1  message in progress
- done  out  1  one-cycle pulse after length block accepted
- err  out  1  sticky: word with in_bytes<16 and in_last=0 seen; cleared by start

## Operation
- States: IDLE, CLEAR, AAD, CT, LEN, FIN.
- IDLE: busy=0. start -> CLEAR; latch has_aad/has_ct; zero len_a, len_c, err.
- CLEAR: ghash_start=1 for exactly one cycle. Next state is AAD if has_aad, else CT if has_ct, else LEN.
- AAD/CT: on in_valid&&in_ready, register ghash_data = in_data with bytes >= n forced to 0, and set ghash_valid. Add n*8 to len_a or len_c; LEN_W arithmetic wraps mod 2^64. On in_last, AAD -> CT (if has_ct) or LEN; CT -> LEN.
- LEN: once the output register is free, load {len_a, len_c} with ghash_valid=1. On acceptance -> FIN.
- FIN: done=1 for one cycle -> IDLE.
- ghash_valid holds, with ghash_data stable, until ghash_ready. The block is accepted on ghash_valid&&ghash_ready.
- in_ready = (state is AAD or CT) && (!ghash_valid || ghash_ready). It is 0 in IDLE, CLEAR, LEN and FIN.
- Partial word without in_last: padded and counted as n bytes; err set.
- start in any non-IDLE state: abort. Drop pending ghash_valid, zero counters and err, go to CLEAR. start beats in_valid in the same cycle.
- The sequencer does not check or monitor in_sel; sections are delimited only by in_last.

## Timing
- Reset values: in_ready=0, ghash_start=0, ghash_data=0, ghash_valid=0, busy=0, done=0, err=0, state IDLE, counters 0.
- start at cycle t: ghash_start=1 at t+1. in_ready=1 from t+2 at the earliest.
- Input accepted at cycle t: ghash_valid=1 at t+1. With ghash_ready held high, throughput is one block per cycle.
- The length block appears the cycle after the final CT or AAD block is accepted, or at CLEAR+1 if both sections are empty.
- done follows length-block acceptance by one cycle. busy=1 from the cycle after start through FIN.
- Reset mid-message returns all outputs to reset values immediately (asynchronous).

## Structure
- Package gcm_pkg:
  - state enum
  - BLK_W, LEN_W constants
  - byte-mask function (n -> 128-bit mask)
  - length-block pack function
- Sub-module gcm_byte_pad: combinational zero-pad of in_data by in_bytes. This is the only sub-module.
- One FSM plus the output register and two length counters live in gcm_ghash_sequencer.

## Test plan
- AAD = 20 bytes (word 16 B + word 4 B, last), CT = 16 B (last). Required output: ghash_start pulse, then 4 blocks: AAD0; AAD1 with bytes 4..15 = 0; CT0; {64'd160, 64'd128}. done pulses once.
- has_aad=0, has_ct=0: ghash_start, then a single block 128'h0, then done. in_ready never asserts.
- CT only, 3 full words, ghash_ready toggling 1-0-0-1. Each block holds stable while not ready; no word is lost or duplicated. Length block = {64'd0, 64'd384}.
- Non-last word with in_bytes=7: err=1 and stays 1 through done. Next start clears err.
- start pulsed while a CT block is pending with ghash_ready=0: ghash_valid drops, ghash_start pulses, and the new message's length block excludes old bytes.
- reset asserted mid-AAD: all outputs are 0 in the same cycle. After release, state is IDLE and in_ready=0.
